// File: rtl/joint_marker_vga.sv
// VGA timing generator that draws a square marker at each of four joints, committing new joint sets at vertical blank.
// Build macro MARKER_CROSSHAIR_EN: when defined, each marker is drawn as a cross instead of a filled square.
module joint_marker_vga #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MARKER_HALF = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       done,
    input  logic [9:0] x_1,
    input  logic [9:0] y_1,
    input  logic [9:0] x_2,
    input  logic [9:0] y_2,
    input  logic [9:0] x_3,
    input  logic [9:0] y_3,
    input  logic [9:0] x_4,
    input  logic [9:0] y_4,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_update
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] HALF     = 11'(MARKER_HALF);

    logic [9:0] r_hcount, r_vcount;
    logic       r_done_meta, r_done_sync, r_done_prev;
    logic       r_pending, r_have_frame;
    logic [9:0] r_sh_x [4];
    logic [9:0] r_sh_y [4];
    logic [9:0] r_act_x [4];
    logic [9:0] r_act_y [4];
    logic [3:0] r_sh_r, r_sh_g, r_sh_b;
    logic [3:0] r_act_r, r_act_g, r_act_b;

    logic [9:0]  w_in_x [4];
    logic [9:0]  w_in_y [4];
    logic        w_capture, w_commit, w_commit_go, w_visible, w_draw;
    logic [3:0]  w_hit;
    logic [10:0] w_h11, w_v11;

    assign w_in_x[0] = x_1;
    assign w_in_y[0] = y_1;
    assign w_in_x[1] = x_2;
    assign w_in_y[1] = y_2;
    assign w_in_x[2] = x_3;
    assign w_in_y[2] = y_3;
    assign w_in_x[3] = x_4;
    assign w_in_y[3] = y_4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    // done is asynchronous to the pixel clock; only the synchronised rising edge triggers a capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_meta <= 1'b0;
            r_done_sync <= 1'b0;
            r_done_prev <= 1'b0;
        end else begin
            r_done_meta <= done;
            r_done_sync <= r_done_meta;
            r_done_prev <= r_done_sync;
        end
    end

    assign w_capture   = r_done_sync & ~r_done_prev;
    assign w_commit    = (r_hcount == '0) && (r_vcount == V_VIS);
    assign w_commit_go = w_commit & r_pending;

    // Commit reads the shadow before a same-cycle capture overwrites it, so the new set waits for the next blank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_sh_x[i]  <= '0;
                r_sh_y[i]  <= '0;
                r_act_x[i] <= '0;
                r_act_y[i] <= '0;
            end
            r_sh_r       <= '0;
            r_sh_g       <= '0;
            r_sh_b       <= '0;
            r_act_r      <= '0;
            r_act_g      <= '0;
            r_act_b      <= '0;
            r_pending    <= 1'b0;
            r_have_frame <= 1'b0;
            frame_update <= 1'b0;
        end else begin
            frame_update <= w_commit_go;
            if (w_commit_go) begin
                for (int i = 0; i < 4; i++) begin
                    r_act_x[i] <= r_sh_x[i];
                    r_act_y[i] <= r_sh_y[i];
                end
                r_act_r      <= r_sh_r;
                r_act_g      <= r_sh_g;
                r_act_b      <= r_sh_b;
                r_have_frame <= 1'b1;
            end
            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    r_sh_x[i] <= w_in_x[i];
                    r_sh_y[i] <= w_in_y[i];
                end
                r_sh_r    <= r;
                r_sh_g    <= g;
                r_sh_b    <= b;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_h11 = {1'b0, r_hcount};
    assign w_v11 = {1'b0, r_vcount};

    // Comparisons are widened to 11 bits and the half-width is added on both sides, so nothing underflows near 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_joint
        logic [10:0] w_x11, w_y11;
        logic        w_on_screen, w_in_box;
        assign w_x11       = {1'b0, r_act_x[gi]};
        assign w_y11       = {1'b0, r_act_y[gi]};
        assign w_on_screen = (r_act_x[gi] < H_VIS) && (r_act_y[gi] < V_VIS);
        assign w_in_box    = (w_h11 + HALF >= w_x11) && (w_h11 <= w_x11 + HALF)
                          && (w_v11 + HALF >= w_y11) && (w_v11 <= w_y11 + HALF);
`ifdef MARKER_CROSSHAIR_EN
        assign w_hit[gi] = w_on_screen && w_in_box
                        && ((r_hcount == r_act_x[gi]) || (r_vcount == r_act_y[gi]));
`else
        assign w_hit[gi] = w_on_screen && w_in_box;
`endif
    end

    assign w_visible = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign w_draw    = w_visible && r_have_frame && (|w_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= !((r_hcount >= HS_START) && (r_hcount < HS_END));
            vsync <= !((r_vcount >= VS_START) && (r_vcount < VS_END));
            vga_r <= w_draw ? r_act_r : 4'd0;
            vga_g <= w_draw ? r_act_g : 4'd0;
            vga_b <= w_draw ? r_act_b : 4'd0;
        end
    end
endmodule

// File: doc/joint_marker_vga.md
# joint_marker_vga

Downstream consumer of the SPI frame receiver: takes the four decoded joint coordinates (`x_1`..`y_4`, 10-bit) and the 4-bit `r`/`g`/`b` colour. It generates 640x480@60 VGA timing from the pixel clock and draws a square marker, in the received colour, centred on each joint. New coordinate sets are captured on the rising edge of the receiver's `done` level and committed to the display only at the start of vertical blanking, so a frame never tears.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels (line total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines (frame total 525)
- `MARKER_HALF`, 4, marker half-width in pixels (marker is 2*MARKER_HALF+1 square)
- `clk` input 1: pixel clock (25.175 MHz); only clock of the block
- `reset_n` input 1: asynchronous, active-low reset
- `done` input 1: frame-valid level from the SPI stage; asynchronous to `clk`
- `x_1`,`y_1`,`x_2`,`y_2`,`x_3`,`y_3`,`x_4`,`y_4` input 10 each: joint coordinates; stable while `done` high
- `r`,`g`,`b` input 4 each: marker colour; stable while `done` high
- `hsync`,`vsync` output 1 each: active-low sync
- `vga_r`,`vga_g`,`vga_b` output 4 each: pixel colour
- `frame_update` output 1: one-cycle pulse when a new coordinate set is committed

## Operation
- `hcount` counts 0..799 and wraps to 0; `vcount` increments on hcount wrap, counts 0..524, then wraps to 0.
- `done` passes a 2-flop synchroniser. A rising edge of the synchronised level loads the shadow registers from all 8 coordinates plus r/g/b and sets `pending`.
- Commit occurs on the cycle where `hcount==0 && vcount==V_ACTIVE`:
  - If `pending`, copy shadow to active, clear `pending`, set `have_frame`, and pulse `frame_update`.
- Simultaneous events:
  - A capture edge on the commit cycle: commit uses the old shadow; the new data loads the shadow and stays pending for the next blank.
  - A second capture before commit overwrites the shadow (latest wins).
- A joint i is hit when all of the following hold (11-bit unsigned arithmetic, no underflow):
  - `hcount + MARKER_HALF >= x_i` and `hcount <= x_i + MARKER_HALF`
  - the same test for `vcount` against `y_i`
- Joints with `x_i >= H_ACTIVE` or `y_i >= V_ACTIVE` are never drawn. Markers clip naturally at screen edges.
- Pixel colour:
  - Visible region, `have_frame`=1 and any joint hit: active r/g/b.
  - All other cases (including blanking): 0.
  - Overlapping markers are not blended; same colour.

## Timing
- Async reset values:
  - Counters, shadow, active registers: 0.
  - `pending`, `have_frame`, `frame_update`: 0.
  - `hsync`, `vsync`: 1; `vga_*`: 0.
  - Synchroniser flops: 0.
- Reset deasserted: first counted pixel (0,0) on the first rising `clk`.
- Reset mid-frame: all outputs return to reset values immediately. Any pending capture is lost.
- Output pipeline: one register stage. `hsync`/`vsync`/`vga_*` at cycle n reflect the counter state at n-1.
- `hsync` low while `hcount` is in [656,751]. `vsync` low while `vcount` is in [490,491] (registered, same 1-cycle lag).
- `done` rise to shadow load: 3 `clk` cycles (2 synchroniser flops + edge register). Shadow to screen: next commit point, at most one frame (420000 cycles) later.
- `frame_update` is asserted on the cycle after the commit cycle, for exactly 1 cycle.

## Configuration
- `MARKER_CROSSHAIR_EN`:
  - Defined: a marker pixel is drawn only where the square test holds AND (`hcount==x_i` OR `vcount==y_i`), i.e. a 9x9 cross.
  - Undefined: filled square, as above.
- Timing and capture logic are identical in both builds.

## Test plan
- Reset, run 2 frames, no `done` -> hsync period 800 cycles, low for 96; vsync period 420000 cycles, low for 1600; `vga_*` always 0; `frame_update` never pulses.
- Raise `done` with x_1=100, y_1=50, others 700/500, rgb=F/0/A, mid-frame at vcount=10 -> no marker drawn that frame. `frame_update` pulses once at vcount=480. In the next frame, pixels x 96..104, y 46..54 are F/0/A and all other pixels are 0.
- Joint at (0,0), MARKER_HALF=4 -> coloured pixels at x 0..4, y 0..4 only; no wrap to x~1023 or line 524.
- Two `done` edges before blank, with x_1=100 then x_1=200 -> only x=200 is displayed; exactly one `frame_update`.
- Assert `reset_n`=0 at vcount=300 with a capture pending -> outputs go to reset values immediately. After release, no marker appears until a new `done` edge.
- Build with `MARKER_CROSSHAIR_EN`, joint (320,240) -> colour only at row 240 x 316..324 and column 320 y 236..244 (17 pixels).
